// File: rtl/serial_framer_pkg.sv
// Shared types and defaults for the serial parity framer.
// The FSM state encoding is visible to any block that needs to decode it.
package serial_framer_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } framer_state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/par_to_ser_shift.sv
// Parallel-load, LSB-first shift register with a data-bit counter.
// The last_data_bit flag marks the final data bit of a frame.
module par_to_ser_shift #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] data,
    output logic             lsb,
    output logic             last_data_bit
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;

    assign lsb           = shreg[0];
    assign last_data_bit = (cnt == CW'(WIDTH - 1));

    // Load wins over shift; the counter wraps to 0 after the final data bit
    // so it never exceeds WIDTH-1 for non power-of-two widths.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            cnt   <= '0;
        end else if (shift) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= last_data_bit ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_parity_framer.sv
// Serialises a parallel word LSB first over valid/ready, followed by one parity bit.
// A new word may be accepted in the same cycle the parity bit is consumed.
module serial_parity_framer
    import serial_framer_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit ODD_PARITY = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             down_valid,
    input  logic             down_ready,
    output logic             down_bit,
    output logic             down_last
);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // down_valid never drops mid-frame; up_ready only depends on state,
    // down_ready and rst, so no path from up_valid reaches it.
    framer_state_t state, state_nxt;
    logic          acc;
    logic          up_xfer, down_xfer;
    logic          load, shift;
    logic          lsb, last_data_bit;

    assign up_xfer   = up_valid && up_ready;
    assign down_xfer = down_valid && down_ready;
    assign load      = up_xfer;
    assign shift     = (state == DATA) && down_xfer;

    par_to_ser_shift #(
        .WIDTH(WIDTH)
    ) u_shift (
        .clk          (clk),
        .rst          (rst),
        .load         (load),
        .shift        (shift),
        .data         (up_data),
        .lsb          (lsb),
        .last_data_bit(last_data_bit)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            acc   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (load) begin
                acc <= ODD_PARITY;
            end else if (shift) begin
                acc <= acc ^ lsb;
            end
        end
    end

    always_comb begin
        up_ready   = 1'b0;
        down_valid = 1'b0;
        down_bit   = 1'b0;
        down_last  = 1'b0;
        case (state)
            IDLE: begin
                up_ready = !rst;
            end
            DATA: begin
                down_valid = 1'b1;
                down_bit   = lsb;
            end
            PARITY: begin
                down_valid = 1'b1;
                down_bit   = acc;
                down_last  = 1'b1;
                up_ready   = down_ready && !rst;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (up_xfer) state_nxt = DATA;
            end
            DATA: begin
                if (down_xfer && last_data_bit) state_nxt = PARITY;
            end
            PARITY: begin
                if (down_xfer) state_nxt = up_xfer ? DATA : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_serial_parity_framer.sv
// Bench for serial_parity_framer: even- and odd-parity instances share all inputs;
// a frame-level scoreboard plus directed vectors and multi-cycle sequences.
module tb_serial_parity_framer;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_ready;
    logic             up_ready0, down_valid0, down_bit0, down_last0;
    logic             up_ready1, down_valid1, down_bit1, down_last1;

    serial_parity_framer #(.WIDTH(WIDTH), .ODD_PARITY(1'b0)) dut_even (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready0), .up_data(up_data),
        .down_valid(down_valid0), .down_ready(down_ready), .down_bit(down_bit0), .down_last(down_last0)
    );

    serial_parity_framer #(.WIDTH(WIDTH), .ODD_PARITY(1'b1)) dut_odd (
        .clk(clk), .rst(rst), .up_valid(up_valid), .up_ready(up_ready1), .up_data(up_data),
        .down_valid(down_valid1), .down_ready(down_ready), .down_bit(down_bit1), .down_last(down_last1)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int n_tests = 0;
    int n_fail  = 0;
    int ready_mode = 0;           // 0 = driven by test, 1 = toggle, 2 = random

    logic [2:0] exp_q[$];         // {last, even-parity bit, odd-parity bit}
    logic [2:0] obs_q[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Reference model: a frame is the data bits LSB first, then the parity bit.
    function automatic void push_frame(input logic [WIDTH-1:0] d);
        int ones = 0;
        for (int i = 0; i < WIDTH; i++) ones += int'(d[i]);
        for (int i = 0; i < WIDTH; i++) exp_q.push_back({1'b0, d[i], d[i]});
        exp_q.push_back({1'b1, logic'(ones % 2 == 1), logic'(ones % 2 == 0)});
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic       stall_pend = 1'b0;
    logic       acc_pend   = 1'b0;
    logic [2:0] prev_out   = '0;
    logic [2:0] mon_e;
    int         cur_run    = 0;
    int         last_run   = 0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            stall_pend = 1'b0;
            acc_pend   = 1'b0;
            cur_run    = 0;
        end else begin
            if (acc_pend) check("first_bit_latency", {down_valid0, down_last0}, 2'b10);
            if (stall_pend)
                check("stall_hold", {down_valid0, down_last0, down_bit0, down_bit1}, {1'b1, prev_out});
            if (!down_valid0)     check("up_ready_idle", up_ready0, 1);
            else if (!down_last0) check("up_ready_data", up_ready0, 0);
            else                  check("up_ready_parity", up_ready0, down_ready);
            check("odd_inst_valid", down_valid1, down_valid0 ? 1 : 0);

            if (down_valid0) cur_run++;
            else begin
                if (cur_run != 0) last_run = cur_run;
                cur_run = 0;
            end

            if (down_valid0 && down_ready) begin
                obs_q.push_back({down_last0, down_bit0, down_bit1});
                if (exp_q.size() == 0) fail_now("unexpected_bit");
                else begin
                    mon_e = exp_q.pop_front();
                    check("sb_bit", {down_last0, down_bit0, down_bit1}, mon_e);
                    check("sb_last_odd", down_last1, mon_e[2]);
                end
            end

            acc_pend = up_valid && up_ready0;
            if (acc_pend) push_frame(up_data);
            stall_pend = down_valid0 && !down_ready;
            prev_out   = {down_last0, down_bit0, down_bit1};
        end
    end

    // ---------------- drivers ----------------
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: down_ready = ~down_ready;
                2: down_ready = ($urandom_range(0, 3) != 0);
                default: ;
            endcase
        end
    end

    task automatic send_word(input logic [WIDTH-1:0] d);
        bit done = 1'b0;
        up_valid = 1'b1;
        up_data  = d;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            if (up_ready0) done = 1'b1;
        end
        if (!done) fail_now("send_timeout");
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        up_data  = WIDTH'($urandom);
    endtask

    task automatic wait_obs(input int n);
        bit done = 1'b0;
        for (int k = 0; k < 400 && !done; k++) begin
            @(negedge clk);
            if (obs_q.size() >= n) done = 1'b1;
        end
        if (!done) fail_now("obs_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int k = 0; k < 2000 && !done; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !down_valid0) done = 1'b1;
        end
        if (!done) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input int base, input logic [WIDTH-1:0] d,
                               input logic pe, input logic po);
        logic [2:0] o;
        logic [2:0] e;
        for (int j = 0; j <= WIDTH; j++) begin
            o = obs_q[base + j];
            if (j < WIDTH) e = {1'b0, d[j], d[j]};
            else           e = {1'b1, pe, po};
            check($sformatf("frame_%0h_bit%0d", d, j), o, e);
        end
    endtask

    // ---------------- test sequence ----------------
    typedef struct {
        logic [WIDTH-1:0] data;
        logic             par_even;
        logic             par_odd;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'hA5, 1'b0, 1'b1};
        vecs[1] = '{8'h07, 1'b1, 1'b0};
        vecs[2] = '{8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1};
        vecs[4] = '{8'h01, 1'b1, 1'b0};
        vecs[5] = '{8'h81, 1'b0, 1'b1};
        vecs[6] = '{8'h5A, 1'b0, 1'b1};
        vecs[7] = '{8'h80, 1'b1, 1'b0};

        // Reset held with an upstream word pending
        rst        = 1'b1;
        up_valid   = 1'b1;
        up_data    = 8'h5A;
        down_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_up_ready",   up_ready0,   0);
        check("rst_down_valid", down_valid0, 0);
        check("rst_down_last",  down_last0,  0);
        check("rst_down_bit",   down_bit0,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("release_up_ready", up_ready0, 1);
        @(posedge clk);
        #1;
        up_valid = 1'b0;
        wait_drain();

        // Directed vectors, down_ready held high
        foreach (vecs[i]) begin
            obs_q.delete();
            send_word(vecs[i].data);
            wait_obs(WIDTH + 1);
            check_frame(0, vecs[i].data, vecs[i].par_even, vecs[i].par_odd);
            wait_drain();
        end

        // Backpressure: down_ready toggles every cycle
        obs_q.delete();
        ready_mode = 1;
        send_word(8'h3C);
        wait_obs(WIDTH + 1);
        check_frame(0, 8'h3C, 1'b0, 1'b1);
        ready_mode = 0;
        down_ready = 1'b1;
        wait_drain();

        // Back-to-back frames with up_valid held high
        begin
            bit done = 1'b0;
            obs_q.delete();
            up_valid = 1'b1;
            up_data  = 8'hFF;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (up_ready0) done = 1'b1;
            end
            if (!done) fail_now("b2b_first_accept_timeout");
            @(posedge clk);
            #1;
            up_data = 8'h01;
            done    = 1'b0;
            for (int k = 0; k < 50 && !done; k++) begin
                @(negedge clk);
                if (up_ready0) done = 1'b1;
            end
            if (!done) fail_now("b2b_second_accept_timeout");
            check("b2b_accept_on_parity", down_last0, 1);
            @(posedge clk);
            #1;
            up_valid = 1'b0;
            wait_obs(2 * (WIDTH + 1));
            wait_drain();
            check_frame(0, 8'hFF, 1'b0, 1'b1);
            check_frame(WIDTH + 1, 8'h01, 1'b1, 1'b0);
            check("b2b_no_bubble_run", last_run, 2 * (WIDTH + 1));
        end

        // Reset mid-frame after 3 data bits, asserted between clock edges
        obs_q.delete();
        send_word(8'hF0);
        wait_obs(3);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_down_valid", {down_valid0, down_valid1}, 2'b00);
        check("async_rst_up_ready",   {up_ready0, up_ready1}, 2'b00);
        check("async_rst_down_last",  down_last0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        obs_q.delete();
        send_word(8'h81);
        wait_obs(WIDTH + 1);
        check_frame(0, 8'h81, 1'b0, 1'b1);
        wait_drain();

        // Randomized words, gaps and backpressure against the scoreboard
        ready_mode = 2;
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
            send_word(WIDTH'($urandom));
        end
        ready_mode = 0;
        down_ready = 1'b1;
        wait_drain();
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_parity_framer.md
Name: serial_parity_framer

Overview:
- Sequential stage that sits directly upstream of the combinational XOR/mux parity checker.
- Accepts a parallel word over a valid/ready handshake and emits it serially, LSB first, one bit per downstream transfer.
- Follows the data bits with a single parity bit, produced by a running XOR accumulator.
- The downstream checker recomputes XOR over the frame to detect bit errors.

Parameters:
- WIDTH, 8, number of data bits per frame; legal range is WIDTH >= 2.
- ODD_PARITY, 0, parity mode: 0 = even parity (total ones in the frame, including the parity bit, is even); 1 = odd parity.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- up_valid  input  1  upstream word valid.
- up_ready  output  1  framer can accept a word this cycle.
- up_data  input  WIDTH  parallel word; sampled only on an accepted transfer.
- down_valid  output  1  down_bit is valid.
- down_ready  input  1  downstream consumes down_bit this cycle.
- down_bit  output  1  current serial bit: a data bit, or the parity bit.
- down_last  output  1  high only while the parity bit is presented.

Behaviour:
- Transfer definitions:
  - Upstream transfer = up_valid && up_ready.
  - Downstream transfer = down_valid && down_ready.
- Reset (asynchronous assert, synchronous release):
  - State forced to IDLE; shift register, bit counter and parity accumulator cleared to 0.
  - down_valid, down_bit and down_last are 0.
  - up_ready is 0 while rst is high, and 1 in the first cycle after release.
- States: IDLE, DATA, PARITY.
- IDLE:
  - up_ready = 1; down_valid = 0.
  - On an upstream transfer: shreg <= up_data, cnt <= 0, acc <= ODD_PARITY, next state DATA.
- DATA:
  - down_valid = 1, down_bit = shreg[0], down_last = 0, up_ready = 0.
  - On a downstream transfer: acc <= acc ^ shreg[0], shreg shifts right (zero fill), cnt <= cnt + 1.
  - When cnt == WIDTH-1 and a transfer occurs, next state is PARITY.
- PARITY:
  - down_valid = 1, down_bit = acc, down_last = 1.
  - up_ready = down_ready (combinational pass-through).
  - On a downstream transfer with no simultaneous upstream transfer: next state IDLE.
  - On a downstream transfer with a simultaneous upstream transfer: load the new word exactly as in IDLE and go to DATA. This gives back-to-back frames with no bubble.
- Latency and throughput:
  - First data bit is presented the cycle after acceptance.
  - Sustained throughput is WIDTH+1 cycles per word when down_ready is held high.
- Stall rule: while down_valid && !down_ready, down_bit, down_last and all internal state hold unchanged.
- up_data is ignored outside an upstream transfer; changing it mid-frame has no effect.
- Counter width is $clog2(WIDTH); cnt never exceeds WIDTH-1 and is not used in PARITY.
- Parity definition: parity bit = XOR of all WIDTH data bits, XOR ODD_PARITY.
- Reset mid-frame: the partial frame is discarded and no parity bit is emitted. The first frame after release starts clean.
- down_valid never drops mid-frame, not even under backpressure.

Decomposition:
- Shared package serial_framer_pkg holds:
  - typedef enum logic [1:0] { IDLE, DATA, PARITY } framer_state_t;
  - localparam default WIDTH.
- One sub-module is natural: par_to_ser_shift. It contains the shift register plus bit counter, with load/shift enables and a last_data_bit flag.
- The FSM, accumulator and handshake logic stay in the top module.

Test Plan:
- Reset: hold rst with up_valid=1 -> up_ready=0, down_valid=0, down_last=0. After release, up_ready=1 next cycle; assert rst asynchronously mid-cycle -> outputs drop with no clock edge.
- Even frame: WIDTH=8, ODD_PARITY=0, up_data=8'hA5, down_ready=1 -> down_bit sequence 1,0,1,0,0,1,0,1 then parity 0. down_last is high only on the 9th transfer; up_ready is 0 during DATA.
- Parity modes: 8'h07 with ODD_PARITY=0 -> parity 1; same word with ODD_PARITY=1 -> parity 0; 8'h00 with ODD_PARITY=1 -> parity 1.
- Backpressure: 8'h3C with down_ready toggling 0,1 every cycle -> down_bit stable across each stall. Exactly 9 transfers yield 0,0,1,1,1,1,0,0 then parity 0.
- Back-to-back: up_valid held high with 8'hFF then 8'h01, down_ready=1. Second word is accepted in the cycle its predecessor's parity transfers. Result is 18 consecutive down_valid cycles, parities 0 and 1, no bubble.
- Reset mid-frame: 8'hF0, assert rst after 3 data bits -> down_valid=0 immediately. After release, 8'h81 produces a clean 9-bit frame 1,0,0,0,0,0,0,1 with parity 0.
